sync_fifo_v2: RTL and testbench
===============================

# sync_fifo_v2

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds several capabilities:

- arbitrary power-of-two depth and data width;
- a selectable read mode: registered read, or first-word-fall-through (FWFT);
- run-time programmable almost-full and almost-empty thresholds;
- an occupancy count output;
- sticky overflow and underflow error flags.

It sits between a producer and a consumer that share one clock, and is the default buffer for new datapath stages.

## Interface

Parameters:
- DWIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AWIDTH, $clog2(DEPTH), derived localparam, not overridable
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- in_data  in  DWIDTH  write data
- rd_en  in  1  read request (pop)
- out_data  out  DWIDTH  read data
- out_valid  out  1  out_data holds valid data (see Operation)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almostfull  out  1  count ≥ af_thresh
- almostempty  out  1  count ≤ ae_thresh
- count  out  AWIDTH+1  current occupancy, 0..DEPTH
- af_thresh  in  AWIDTH+1  almost-full threshold, quasi-static
- ae_thresh  in  AWIDTH+1  almost-empty threshold, quasi-static
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty
- err_clr  in  1  clears overflow and underflow

## Operation

Pointers:
- wptr and rptr are AWIDTH+1 bits; the low AWIDTH bits address the RAM and the MSB is the wrap bit.
- count = wptr − rptr, computed modulo 2^(AWIDTH+1).
- full = (MSBs differ and low bits equal). empty = (wptr == rptr).

Accept rules, evaluated on pre-edge state:
- A write is accepted when wr_en && !full.
- A read is accepted when rd_en && !empty.
- Full with wr_en=1, rd_en=1: the read is accepted, the write is rejected and overflow is set.
- Empty with wr_en=1, rd_en=1: the write is accepted, the read is rejected and underflow is set.
- Partially filled with both requests: both are accepted and count is unchanged.

Mode FWFT=0 (registered read):
- An accepted read registers ram[rptr] into out_data at that edge.
- out_valid is high for exactly the following cycle.
- out_data holds its value when no read is accepted.

Mode FWFT=1 (first-word-fall-through):
- out_data = ram[rptr] combinationally; out_valid = !empty.
- rd_en pops the head entry. The next entry, if any, appears in the same cycle after the edge.
- A word written into an empty FIFO is visible on out_data the cycle after the write edge.

Thresholds:
- almostfull and almostempty are combinational compares of count against the threshold inputs.
- af_thresh = 0 forces almostfull = 1.
- ae_thresh ≥ DEPTH forces almostempty = 1.

Error flags:
- overflow is set on an edge with wr_en && full.
- underflow is set on an edge with rd_en && empty.
- err_clr clears both flags on the edge.
- Set and clear in the same cycle: set wins.

RAM is not reset. Its contents are undefined until written.

## Timing

Reset values while rst=1, applied asynchronously:
- wptr = 0, rptr = 0, count = 0
- empty = 1, full = 0
- almostempty = (ae_thresh ≥ 0) = 1; almostfull = (af_thresh == 0)
- out_data = 0 (FWFT=0); out_valid = 0
- overflow = 0, underflow = 0

Reset behaviour:
- Asserting rst mid-operation discards all entries immediately. There is no flush handshake.
- Deassertion is synchronised externally. The first accepted write can occur on the first rising edge with rst=0.

Latency:
- FWFT=0: a write at edge N can be read at edge N+1; data is on out_data after edge N+1.
- FWFT=1: a write at edge N puts data on out_data after edge N.
- full, empty and count update on the edge that changes the pointers. They have no combinational path from wr_en or rd_en.

Write-to-read bypass: none. A write to an empty FIFO is never read in the same cycle.

## Test plan

All scenarios use DWIDTH=8, DEPTH=16.

- Reset then idle -> empty=1, full=0, count=0, out_valid=0, overflow=0, underflow=0.
- FWFT=0: write 0x01..0x10 (16 words) -> full=1 and count=16 after the 16th edge. Then read 16 -> out_data 0x01..0x10 in order, each with a one-cycle out_valid pulse. Finally empty=1.
- Full plus one write (0xAA) with rd_en=0 -> write rejected, overflow=1, count stays 16. Pulse err_clr -> overflow=0. Same test with rd_en=1 at full -> count=15, overflow=1.
- FWFT=1: single write of 0x5C into an empty FIFO -> out_valid=1 and out_data=0x5C one cycle later. rd_en -> empty=1, out_valid=0. An extra rd_en -> underflow=1.
- Thresholds af=12, ae=3: fill 0→16 -> almostempty is high for count ≤3 and almostfull is high from count 12. Streaming with wr_en=rd_en=1 for 100 cycles at count=8 with random data -> count stays 8, the data order is preserved, and the pointers wrap correctly.
- Assert rst at count=9 mid-stream -> all outputs take their reset values asynchronously, before the next clock edge. Next write 0x33, then read -> 0x33 (no stale data).

Source files
------------

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with registered or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_v2 #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int FWFT   = 0,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  output logic              full,
  output logic              empty,
  output logic              almostfull,
  output logic              almostempty,
  output logic [AWIDTH:0]   count,
  input  logic [AWIDTH:0]   af_thresh,
  input  logic [AWIDTH:0]   ae_thresh,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  // Handshake: wr_en pushes in_data when !full, rd_en pops the head when !empty;
  // both are judged on pre-edge state and a refused request only raises its error flag.

  logic [AWIDTH:0]   r_wptr;
  logic [AWIDTH:0]   r_rptr;
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic              r_overflow;
  logic              r_underflow;

  logic [AWIDTH:0]   w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  assign w_count  = r_wptr - r_rptr;
  assign w_full   = (r_wptr[AWIDTH] != r_rptr[AWIDTH]) &&
                    (r_wptr[AWIDTH-1:0] == r_rptr[AWIDTH-1:0]);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr[AWIDTH-1:0]] <= in_data;
  end

  // Set wins over clear so an error in the clearing cycle is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full)      r_overflow <= 1'b1;
      else if (err_clr)         r_overflow <= 1'b0;
      if (rd_en && w_empty)     r_underflow <= 1'b1;
      else if (err_clr)         r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign out_data  = r_mem[r_rptr[AWIDTH-1:0]];
      assign out_valid = !w_empty;
    end else begin : g_reg
      logic [DWIDTH-1:0] r_out_data;
      logic              r_out_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= w_rd_acc;
          if (w_rd_acc) r_out_data <= r_mem[r_rptr[AWIDTH-1:0]];
        end
      end

      assign out_data  = r_out_data;
      assign out_valid = r_out_valid;
    end
  endgenerate

  assign count       = w_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almostfull  = (w_count >= af_thresh);
  assign almostempty = (w_count <= ae_thresh);
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Drives a registered-read and an FWFT instance with identical traffic and checks
// both against a queue-based reference of the FIFO rules.
module tb_sync_fifo_v2;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW:0]   af_thresh = 5'd12, ae_thresh = 5'd3;

  logic [DW-1:0] od0, od1;
  logic          ov0, ov1, fu0, fu1, em0, em1, af0, af1, ae0, ae1;
  logic          of0, of1, uf0, uf1;
  logic [AW:0]   cn0, cn1;

  sync_fifo_v2 #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .in_data(in_data), .rd_en(rd_en),
    .out_data(od0), .out_valid(ov0), .full(fu0), .empty(em0),
    .almostfull(af0), .almostempty(ae0), .count(cn0),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(of0), .underflow(uf0), .err_clr(err_clr));

  sync_fifo_v2 #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .in_data(in_data), .rd_en(rd_en),
    .out_data(od1), .out_valid(ov1), .full(fu1), .empty(em1),
    .almostfull(af1), .almostempty(ae1), .count(cn1),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(of1), .underflow(uf1), .err_clr(err_clr));

  // reference model / scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_out0 = '0;
  logic          m_vld0 = 1'b0;
  logic          m_ovf  = 1'b0;
  logic          m_udf  = 1'b0;
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    int sz;
    sz = exp_q.size();
    check("count0", 32'(cn0), 32'(sz));
    check("count1", 32'(cn1), 32'(sz));
    check("full0",  32'(fu0), 32'(sz == DEPTH));
    check("full1",  32'(fu1), 32'(sz == DEPTH));
    check("empty0", 32'(em0), 32'(sz == 0));
    check("empty1", 32'(em1), 32'(sz == 0));
    check("afull0", 32'(af0), 32'(sz >= int'(af_thresh)));
    check("afull1", 32'(af1), 32'(sz >= int'(af_thresh)));
    check("aempty0", 32'(ae0), 32'(sz <= int'(ae_thresh)));
    check("aempty1", 32'(ae1), 32'(sz <= int'(ae_thresh)));
    check("ovf0", 32'(of0), 32'(m_ovf));
    check("ovf1", 32'(of1), 32'(m_ovf));
    check("udf0", 32'(uf0), 32'(m_udf));
    check("udf1", 32'(uf1), 32'(m_udf));
    check("valid0", 32'(ov0), 32'(m_vld0));
    check("data0",  32'(od0), 32'(m_out0));
    check("valid1", 32'(ov1), 32'(sz != 0));
    if (sz != 0) check("data1", 32'(od1), 32'(exp_q[0]));
  endtask

  // driver: one clock cycle of requests, model advanced from pre-edge state
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    logic fb, eb, wa, ra;
    wr_en = w; in_data = d; rd_en = r; err_clr = c;
    fb = (exp_q.size() == DEPTH);
    eb = (exp_q.size() == 0);
    wa = w && !fb;
    ra = r && !eb;
    if (ra) m_out0 = exp_q.pop_front();
    if (wa) exp_q.push_back(d);
    m_vld0 = ra;
    if (w && fb) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && eb) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    check_all();
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_out0 = '0; m_vld0 = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  initial begin
    // reset then idle
    #2 check_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);

    // fill 0x01..0x10, thresholds checked at every occupancy
    for (int i = 1; i <= DEPTH; i++) cycle(1, 8'(i), 0, 0);
    check("full_after_fill", 32'(fu0), 32'd1);

    // overflow at full, clear, then simultaneous read+write at full
    cycle(1, 8'hAA, 0, 0);
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'hAB, 1, 0);
    check("count_rw_full", 32'(cn0), 32'd15);
    cycle(1, 8'hAC, 0, 0);
    cycle(1, 8'hAD, 0, 1);   // set and clear together: set wins
    cycle(0, 8'h00, 0, 1);

    // drain everything, then underflow
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 1);

    // both requests while empty: write wins, read flags underflow
    cycle(1, 8'h77, 1, 0);
    cycle(0, 8'h00, 1, 1);

    // single word 0x5C, read, extra read
    cycle(1, 8'h5C, 0, 0);
    check("fwft_5c", 32'(od1), 32'h5C);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 1);

    // fill to 8 and stream 100 cycles at constant occupancy
    for (int i = 0; i < 8; i++) cycle(1, 8'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 100; i++) cycle(1, 8'($urandom_range(0, 255)), 1, 0);

    // random traffic
    for (int i = 0; i < 150; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));

    // threshold extremes
    af_thresh = 5'd0; ae_thresh = 5'd16;
    cycle(0, 8'h00, 0, 0);
    af_thresh = 5'd12; ae_thresh = 5'd3;
    cycle(0, 8'h00, 0, 0);

    // reset mid-stream at count 9
    while (exp_q.size() > 9) cycle(0, 8'h00, 1, 0);
    while (exp_q.size() < 9) cycle(1, 8'($urandom_range(0, 255)), 0, 0);
    rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 8'h33, 0, 0);
    cycle(0, 8'h00, 1, 0);
    check("post_reset_data", 32'(od0), 32'h33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
